// File: rtl/comparator_pkg.sv
// comparator_pkg: shared op/state types and popcount helper for stream_comparator
package comparator_pkg;
  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_LT  = 3'd1,
    OP_GT  = 3'd2,
    OP_LE  = 3'd3,
    OP_GE  = 3'd4,
    OP_NE  = 3'd5,
    OP_SLT = 3'd6,
    OP_SGT = 3'd7
  } cmp_op_e;
  typedef enum logic {IDLE, ACTIVE} frame_state_e;
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += v[i] ? 1 : 0;
    return n;
  endfunction
endpackage

// File: rtl/comparator_lane.sv
// comparator_lane: one combinational compare lane (signed ops need STREAM_COMPARATOR_SIGNED_EN)
module comparator_lane
  import comparator_pkg::*;
#(
  parameter int INPUT_SIZE = 4
) (
  input  cmp_op_e               op,
  input  logic [INPUT_SIZE-1:0] in_0,
  input  logic [INPUT_SIZE-1:0] in_1,
  output logic                  comp_out
);
  always_comb begin
    comp_out = 1'b0;
    case (op)
      OP_EQ:  comp_out = in_1 == in_0;
      OP_LT:  comp_out = in_1 < in_0;
      OP_GT:  comp_out = in_1 > in_0;
      OP_LE:  comp_out = in_1 <= in_0;
      OP_GE:  comp_out = in_1 >= in_0;
      OP_NE:  comp_out = in_1 != in_0;
`ifdef STREAM_COMPARATOR_SIGNED_EN
      OP_SLT: comp_out = $signed(in_1) < $signed(in_0);
      OP_SGT: comp_out = $signed(in_1) > $signed(in_0);
`endif
      default: comp_out = 1'b0;
    endcase
  end
endmodule

// File: rtl/stream_comparator.sv
// stream_comparator: LANES-wide registered comparator with valid/ready and per-frame saturating match count
// Signed ops 6/7 are enabled by defining STREAM_COMPARATOR_SIGNED_EN; otherwise they yield 0.
module stream_comparator
  import comparator_pkg::*;
#(
  parameter int INPUT_SIZE = 4,
  parameter int LANES      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  op,
  input  logic [LANES*INPUT_SIZE-1:0] in_0,
  input  logic [LANES*INPUT_SIZE-1:0] in_1,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0]            comp_out,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        out_last
);
  localparam int PC_W = $clog2(LANES + 1);
  frame_state_e     state;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_next;
  logic [CNT_W:0]   sum;
  logic [PC_W-1:0]  pc;
  logic [LANES-1:0] res;
  logic             in_fire;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    comparator_lane #(.INPUT_SIZE(INPUT_SIZE)) u_lane (
      .op      (cmp_op_e'(op)),
      .in_0    (in_0[l*INPUT_SIZE +: INPUT_SIZE]),
      .in_1    (in_1[l*INPUT_SIZE +: INPUT_SIZE]),
      .comp_out(res[l])
    );
  end
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign pc       = PC_W'(popcount(64'(res)));
  // one extra bit catches the overflow so the count pins at all-ones instead of wrapping
  assign sum      = (state == IDLE ? '0 : {1'b0, acc}) + (CNT_W+1)'(pc);
  assign acc_next = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      comp_out  <= '0;
      match_cnt <= '0;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      state     <= in_last ? IDLE : ACTIVE;
      acc       <= in_last ? '0 : acc_next;
      out_valid <= 1'b1;
      comp_out  <= res;
      match_cnt <= acc_next;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_comparator.sv
// tb_stream_comparator: directed table, corner sequences and random traffic against a queue scoreboard
module tb_stream_comparator;
`ifdef STREAM_COMPARATOR_SIGNED_EN
  localparam logic SGN = 1'b1;
`else
  localparam logic SGN = 1'b0;
`endif
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready, in_ready_b;
  logic [2:0]  op = 0;
  logic [15:0] in_0 = 0, in_1 = 0;
  logic        in_last = 0;
  logic        out_valid, out_valid_b;
  logic        out_ready = 1;
  logic [3:0]  comp_out, comp_out_b;
  logic [7:0]  match_cnt;
  logic [2:0]  match_cnt_b;
  logic        out_last, out_last_b;
  int checks = 0, errors = 0;

  stream_comparator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_0(in_0), .in_1(in_1), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .comp_out(comp_out), .match_cnt(match_cnt), .out_last(out_last)
  );
  stream_comparator #(.CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .op(op),
    .in_0(in_0), .in_1(in_1), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .comp_out(comp_out_b), .match_cnt(match_cnt_b), .out_last(out_last_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] comp;
    int         c8;
    int         c3;
    logic       last;
  } exp_t;
  exp_t q[$];
  bit   m_active = 0;
  int   m_acc8 = 0, m_acc3 = 0;

  function automatic int sval(input logic [3:0] v);
    return v >= 8 ? int'(v) - 16 : int'(v);
  endfunction

  function automatic logic [3:0] ref_cmp(input logic [2:0] o, input logic [15:0] a0, input logic [15:0] a1);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int x, y;
      x = int'(a0[4*i +: 4]);
      y = int'(a1[4*i +: 4]);
      case (o)
        3'd0: r[i] = y == x;
        3'd1: r[i] = y < x;
        3'd2: r[i] = y > x;
        3'd3: r[i] = y <= x;
        3'd4: r[i] = y >= x;
        3'd5: r[i] = y != x;
        3'd6: r[i] = SGN && (sval(a1[4*i +: 4]) < sval(a0[4*i +: 4]));
        default: r[i] = SGN && (sval(a1[4*i +: 4]) > sval(a0[4*i +: 4]));
      endcase
    end
    return r;
  endfunction

  // scoreboard: everything is sampled at negedge where inputs and outputs are settled
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_active = 0; m_acc8 = 0; m_acc3 = 0;
    end else begin
      chk("valid_b", out_valid_b, out_valid);
      chk("ready_b", in_ready_b, in_ready);
      chk("ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out: got out_valid=1 expected no pending beat at %0t", $time);
        end else begin
          chk("sb_comp", comp_out, q[0].comp);
          chk("sb_comp_b", comp_out_b, q[0].comp);
          chk("sb_cnt8", match_cnt, q[0].c8);
          chk("sb_cnt3", match_cnt_b, q[0].c3);
          chk("sb_last", out_last, q[0].last);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int   p;
        e.comp = ref_cmp(op, in_0, in_1);
        p = $countones(e.comp);
        e.c8 = (m_active ? m_acc8 : 0) + p;
        e.c3 = (m_active ? m_acc3 : 0) + p;
        if (e.c8 > 255) e.c8 = 255;
        if (e.c3 > 7) e.c3 = 7;
        e.last = in_last;
        m_active = !in_last;
        m_acc8 = in_last ? 0 : e.c8;
        m_acc3 = in_last ? 0 : e.c3;
        q.push_back(e);
      end
    end
  end

  // call at posedge+2; returns at posedge+2 after the beat has transferred
  task automatic send(input logic [2:0] o, input logic [15:0] a0, input logic [15:0] a1, input logic l);
    int n;
    op = o; in_0 = a0; in_1 = a1; in_last = l; in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 1000 cycles");
    end
    @(posedge clk); #2;
    in_valid = 0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a0;
    logic [15:0] a1;
    logic        last;
    logic [3:0]  comp;
    int          c8;
    int          c3;
  } vec_t;
  vec_t tbl[13];

  bit rnd_done = 0;
  logic [3:0] hold_c;
  logic [7:0] hold_m;

  initial begin
    tbl[0]  = '{3'd0, 16'h1234, 16'h1234, 1'b1, 4'b1111, 4, 4};
    tbl[1]  = '{3'd1, 16'hF435, 16'h0453, 1'b0, 4'b1001, 2, 2};
    tbl[2]  = '{3'd1, 16'hF435, 16'h0453, 1'b1, 4'b1001, 4, 4};
    tbl[3]  = '{3'd0, 16'hAAAA, 16'hAAAA, 1'b0, 4'b1111, 4, 4};
    tbl[4]  = '{3'd0, 16'h5555, 16'h5555, 1'b0, 4'b1111, 8, 7};
    tbl[5]  = '{3'd0, 16'h0000, 16'h0000, 1'b1, 4'b1111, 12, 7};
    tbl[6]  = '{3'd0, 16'h0000, 16'h1000, 1'b1, 4'b0111, 3, 3};
    tbl[7]  = '{3'd6, 16'h0001, 16'h000F, 1'b1, {3'b000, SGN}, SGN ? 1 : 0, SGN ? 1 : 0};
    tbl[8]  = '{3'd7, 16'h000F, 16'h0001, 1'b1, {3'b000, SGN}, SGN ? 1 : 0, SGN ? 1 : 0};
    tbl[9]  = '{3'd4, 16'hF435, 16'h0453, 1'b1, 4'b0110, 2, 2};
    tbl[10] = '{3'd3, 16'hF435, 16'h0453, 1'b1, 4'b1101, 3, 3};
    tbl[11] = '{3'd2, 16'hF435, 16'h0453, 1'b1, 4'b0010, 1, 1};
    tbl[12] = '{3'd5, 16'hF435, 16'h0453, 1'b1, 4'b1011, 3, 3};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_comp", comp_out, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_last", out_last, 0);
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #2;
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].op, tbl[i].a0, tbl[i].a1, tbl[i].last);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_comp", i), comp_out, tbl[i].comp);
      chk($sformatf("tbl%0d_cnt8", i), match_cnt, tbl[i].c8);
      chk($sformatf("tbl%0d_cnt3", i), match_cnt_b, tbl[i].c3);
      chk($sformatf("tbl%0d_last", i), out_last, tbl[i].last);
      @(posedge clk); #2;
    end
    // backpressure: first beat parks in the register, second waits five cycles
    out_ready = 0;
    send(3'd0, 16'h1111, 16'h1111, 1'b0);
    op = 3'd5; in_0 = 16'h0000; in_1 = 16'h0011; in_last = 1; in_valid = 1;
    @(negedge clk);
    hold_c = comp_out; hold_m = match_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", in_ready, 0);
      chk("bp_comp", comp_out, hold_c);
      chk("bp_cnt", match_cnt, hold_m);
      @(negedge clk);
    end
    @(posedge clk); #2;
    out_ready = 1;
    @(posedge clk); #2;
    in_valid = 0;
    @(negedge clk);
    chk("bp_second_cnt", match_cnt, 6);
    chk("bp_second_last", out_last, 1);
    @(posedge clk); #2;
    // reset in the middle of a frame holding count 6
    send(3'd5, 16'h0000, 16'h0111, 1'b0);
    send(3'd5, 16'h0000, 16'h0111, 1'b0);
    @(negedge clk);
    chk("mid_cnt6", match_cnt, 6);
    @(posedge clk); #2;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", match_cnt, 0);
    @(posedge clk); #2;
    rst = 0;
    send(3'd0, 16'h7777, 16'h7777, 1'b1);
    @(negedge clk);
    chk("post_rst_cnt", match_cnt, 4);
    chk("post_rst_last", out_last, 1);
    @(posedge clk); #2;
    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 400; i++)
          send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
               1'($urandom_range(0, 5) == 0));
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #2;
          out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    @(posedge clk); #2;
    out_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish by 2ms");
    $fatal(1, "timeout");
  end
endmodule
